// File: rtl/ctu_clst_pkg.sv
// Shared state encoding and helpers for the CTU cluster clock/reset sequencer.
package ctu_clst_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        S_OFF      = 3'd0,
        S_RAMP_UP  = 3'd1,
        S_RST_HOLD = 3'd2,
        S_RUN      = 3'd3,
        S_DBG      = 3'd4,
        S_RAMP_DN  = 3'd5
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ctu_clst_timer.sv
// Loadable down-counter shared by every timed state of the sequencer; done while it rests at zero.
module ctu_clst_timer
    import ctu_clst_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/ctu_clst_seq.sv
// Cluster clock/reset sequencer: staggered cken ramp, global reset hold, debug-init pulses.
// Optional feature macro: CTU_CLST_SEQ_DBGINIT_EN (DBG state with its own gdbginit_l pulse).
module ctu_clst_seq
    import ctu_clst_pkg::*;
#(
    parameter int NUM_CLST = 8,
    parameter int STAGGER  = 4,
    parameter int RST_HOLD = 16,
    parameter int DBG_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                   gclk,
    input  logic                   arst,
    input  logic                   start,
    input  logic [NUM_CLST-1:0]    cken_mask,
    input  logic                   stop_req,
    output logic                   stop_ack,
    input  logic                   dbg_req,
    output logic                   dbg_ack,
    output logic [NUM_CLST-1:0]    cluster_cken,
    output logic                   grst_l,
    output logic                   gdbginit_l,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic                   busy
);

    localparam int TMAX  = max3(STAGGER, RST_HOLD, DBG_HOLD);
    localparam int IDX_W = $clog2(NUM_CLST + 1);

    localparam logic [CNT_W-1:0] STAG_M1 = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(RST_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CLST - 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_CLST);

    if (STAGGER < 1 || RST_HOLD < 1 || DBG_HOLD < 1) begin : g_bad_hold
        $error("ctu_clst_seq: STAGGER, RST_HOLD and DBG_HOLD must be >= 1");
    end
    if (CNT_W < 31) begin : g_cnt_chk
        if ((1 << CNT_W) <= TMAX) begin : g_bad_cnt_w
            $error("ctu_clst_seq: CNT_W too narrow for the longest hold time");
        end
    end

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_CLST-1:0] mask_q, mask_d;
    logic [NUM_CLST-1:0] cken_q, cken_d;
    logic                grst_l_q, grst_l_d;
    logic                gdbg_l_q, gdbg_l_d;
    logic                stop_pend_q, stop_pend_d;
    logic                stop_ack_q, stop_ack_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic                start_q;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_done;
`ifndef CTU_CLST_SEQ_DBGINIT_EN
    logic                dbg_req_q;
`endif

    ctu_clst_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (gclk),
        .rst   (arst),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        cken_d      = cken_q;
        grst_l_d    = grst_l_q;
        gdbg_l_d    = gdbg_l_q;
        stop_pend_d = stop_pend_q;
        stop_ack_d  = 1'b0;
        dbg_ack_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            S_OFF: begin
                if (start && !start_q) begin
                    state_d     = S_RAMP_UP;
                    idx_d       = '0;
                    mask_d      = cken_mask;
                    stop_pend_d = 1'b0;
                    tmr_load    = 1'b1;
                end
            end
            S_RAMP_UP: begin
                if (stop_req) stop_pend_d = 1'b1;
                if (tmr_done) begin
                    if (idx_q == IDX_END) begin
                        state_d  = S_RST_HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = RST_M1;
                    end else begin
                        // Masked slots still burn their STAGGER cycles so timing is mask-independent.
                        for (int i = 0; i < NUM_CLST; i++) begin
                            if (idx_q == IDX_W'(i)) cken_d[i] = cken_q[i] | mask_q[i];
                        end
                        idx_d    = idx_q + IDX_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = STAG_M1;
                    end
                end
            end
            S_RST_HOLD: begin
                if (stop_req) stop_pend_d = 1'b1;
                if (tmr_done) begin
                    grst_l_d = 1'b1;
                    gdbg_l_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_req || stop_pend_q) begin
                    state_d     = S_RAMP_DN;
                    grst_l_d    = 1'b0;
                    stop_pend_d = 1'b0;
                    idx_d       = IDX_TOP;
                    tmr_load    = 1'b1;
                end
`ifdef CTU_CLST_SEQ_DBGINIT_EN
                else if (dbg_req) begin
                    state_d  = S_DBG;
                    gdbg_l_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(DBG_HOLD - 1);
                end
`endif
            end
`ifdef CTU_CLST_SEQ_DBGINIT_EN
            S_DBG: begin
                if (stop_req) stop_pend_d = 1'b1;
                // First expiry releases gdbginit_l, the extra cycle after it carries the ack.
                if (tmr_done) begin
                    if (!gdbg_l_q) begin
                        gdbg_l_d = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        dbg_ack_d = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
`endif
            S_RAMP_DN: begin
                if (tmr_done) begin
                    if (idx_q == IDX_END) begin
                        state_d    = S_OFF;
                        stop_ack_d = 1'b1;
                        gdbg_l_d   = 1'b0;
`ifdef CTU_CLST_SEQ_DBGINIT_EN
                        dbg_ack_d  = dbg_req;
`endif
                    end else begin
                        for (int i = 0; i < NUM_CLST; i++) begin
                            if (idx_q == IDX_W'(i)) cken_d[i] = 1'b0;
                        end
                        tmr_load = 1'b1;
                        if (idx_q == '0) begin
                            idx_d = IDX_END;
                        end else begin
                            idx_d   = idx_q - IDX_W'(1);
                            tmr_val = STAG_M1;
                        end
                    end
                end
            end
            default: state_d = S_OFF;
        endcase

`ifndef CTU_CLST_SEQ_DBGINIT_EN
        gdbg_l_d  = grst_l_d;
        dbg_ack_d = dbg_req & ~dbg_req_q;
`endif
    end

    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_q     <= S_OFF;
            idx_q       <= '0;
            mask_q      <= '0;
            cken_q      <= '0;
            grst_l_q    <= 1'b0;
            gdbg_l_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            stop_ack_q  <= 1'b0;
            dbg_ack_q   <= 1'b0;
            start_q     <= 1'b1;
`ifndef CTU_CLST_SEQ_DBGINIT_EN
            dbg_req_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            cken_q      <= cken_d;
            grst_l_q    <= grst_l_d;
            gdbg_l_q    <= gdbg_l_d;
            stop_pend_q <= stop_pend_d;
            stop_ack_q  <= stop_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            start_q     <= start;
`ifndef CTU_CLST_SEQ_DBGINIT_EN
            dbg_req_q   <= dbg_req;
`endif
        end
    end

    assign cluster_cken = cken_q;
    assign grst_l       = grst_l_q;
    assign gdbginit_l   = gdbg_l_q;
    assign stop_ack     = stop_ack_q;
    assign dbg_ack      = dbg_ack_q;
    assign seq_state    = state_q;
    assign busy         = (state_q != S_OFF);

endmodule
